// File: rtl/tob_momentum_engine_if.sv
// ----------------------------------------------------------------------------
// tob_momentum_engine_if
// Bundles the two handshake paths of the top-of-book momentum engine:
//   - the decoded-frame strobe from the frame unpacker
//     (msg_valid / msg_type / msg_payload)
//   - the valid/ready order path towards order entry
//     (order_valid / order_ready / order_side / order_px / order_qty)
// Modports:
//   master : the environment side (drives frames and order_ready)
//   slave  : the engine side (consumes frames, offers orders)
// ----------------------------------------------------------------------------
interface tob_momentum_engine_if #(
    parameter int PAYLOAD_LEN = 4,
    parameter int PX_W        = 16,
    parameter int QTY_W       = 16
);
    logic                     msg_valid;
    logic [1:0]               msg_type;
    logic [PAYLOAD_LEN*8-1:0] msg_payload;

    logic                     order_valid;
    logic                     order_ready;
    logic                     order_side;
    logic [PX_W-1:0]          order_px;
    logic [QTY_W-1:0]         order_qty;

    modport master (
        output msg_valid, msg_type, msg_payload, order_ready,
        input  order_valid, order_side, order_px, order_qty
    );

    modport slave (
        input  msg_valid, msg_type, msg_payload, order_ready,
        output order_valid, order_side, order_px, order_qty
    );
endinterface

// File: rtl/tob_momentum_engine.sv
// ----------------------------------------------------------------------------
// tob_momentum_engine
// Keeps a one-level book (best bid / best ask) from decoded frames and, on
// each TRADE, runs a momentum rule that may emit a single order:
//   trade at/through the ask -> BUY at ask, trade at/through the bid -> SELL
//   at bid, quantity clamped to MAX_QTY. After an accepted order the engine
//   idles for COOLDOWN_CYC cycles. Triggers that arrive while busy are
//   counted in a saturating drop counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       frame input and valid/ready order output
//   bid_px/bid_qty    best bid,  bid_vld when populated
//   ask_px/ask_qty    best ask,  ask_vld when populated
//   spread            ask_px-bid_px, 0 when a side is empty or book crossed
//   crossed           both sides valid and ask_px <= bid_px
//   drop_cnt          saturating count of suppressed triggers
// ----------------------------------------------------------------------------
module tob_momentum_engine #(
    parameter int PAYLOAD_LEN  = 4,
    parameter int PX_W         = 16,
    parameter int QTY_W        = 16,
    parameter int MAX_QTY      = 100,
    parameter int COOLDOWN_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tob_momentum_engine_if.slave bus,
    output logic [PX_W-1:0]      bid_px,
    output logic [QTY_W-1:0]     bid_qty,
    output logic                 bid_vld,
    output logic [PX_W-1:0]      ask_px,
    output logic [QTY_W-1:0]     ask_qty,
    output logic                 ask_vld,
    output logic [PX_W-1:0]      spread,
    output logic                 crossed,
    output logic [7:0]           drop_cnt
);

    localparam logic [1:0]       MSG_BID   = 2'd0;
    localparam logic [1:0]       MSG_ASK   = 2'd1;
    localparam logic [1:0]       MSG_TRADE = 2'd2;
    localparam logic [1:0]       MSG_CLEAR = 2'd3;
    localparam logic [QTY_W-1:0] MAX_Q     = QTY_W'(MAX_QTY);

    // Cooldown counter runs 0..COOLDOWN_CYC-1 while in COOL.
    localparam int               CNT_W     = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [CNT_W-1:0] COOL_LAST = (COOLDOWN_CYC > 0) ? CNT_W'(COOLDOWN_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, EVAL, ISSUE, COOL} state_t;

    state_t           state, state_nxt;
    logic [PX_W-1:0]  trade_px;
    logic [CNT_W-1:0] cool_cnt;

    logic [PX_W-1:0]  msg_px;
    logic [QTY_W-1:0] msg_qty;
    logic             is_trade;
    logic             drop;

    logic             take_order;
    logic             eval_side;
    logic [PX_W-1:0]  eval_px;
    logic [QTY_W-1:0] eval_qty;

    assign msg_px   = bus.msg_payload[PAYLOAD_LEN*8-1 -: PX_W];
    assign msg_qty  = bus.msg_payload[QTY_W-1:0];
    assign is_trade = bus.msg_valid && (bus.msg_type == MSG_TRADE);
    assign drop     = is_trade && (state != IDLE);

    assign crossed = bid_vld && ask_vld && (ask_px <= bid_px);
    assign spread  = (bid_vld && ask_vld && !crossed) ? (ask_px - bid_px) : '0;

    assign bus.order_valid = (state == ISSUE);

    // Book and last trade price. Updates in every FSM state; a zero quantity
    // only invalidates the side and leaves the stale level in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            bid_px   <= '0;
            bid_qty  <= '0;
            bid_vld  <= 1'b0;
            ask_px   <= '0;
            ask_qty  <= '0;
            ask_vld  <= 1'b0;
            trade_px <= '0;
        end else if (bus.msg_valid) begin
            case (bus.msg_type)
                MSG_BID: begin
                    if (msg_qty != '0) begin
                        bid_px  <= msg_px;
                        bid_qty <= msg_qty;
                        bid_vld <= 1'b1;
                    end else begin
                        bid_vld <= 1'b0;
                    end
                end
                MSG_ASK: begin
                    if (msg_qty != '0) begin
                        ask_px  <= msg_px;
                        ask_qty <= msg_qty;
                        ask_vld <= 1'b1;
                    end else begin
                        ask_vld <= 1'b0;
                    end
                end
                MSG_CLEAR: begin
                    bid_vld <= 1'b0;
                    ask_vld <= 1'b0;
                end
                default: trade_px <= msg_px;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // EVAL reads the book registers, which still hold the book as it stood
    // at the TRADE edge because a TRADE frame never modifies the book.
    always_comb begin
        state_nxt  = state;
        take_order = 1'b0;
        eval_side  = 1'b0;
        eval_px    = ask_px;
        eval_qty   = (ask_qty > MAX_Q) ? MAX_Q : ask_qty;
        case (state)
            IDLE: begin
                if (is_trade) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                state_nxt = IDLE;
                if (!crossed) begin
                    if (ask_vld && (trade_px >= ask_px)) begin
                        take_order = 1'b1;
                    end else if (bid_vld && (trade_px <= bid_px)) begin
                        take_order = 1'b1;
                        eval_side  = 1'b1;
                        eval_px    = bid_px;
                        eval_qty   = (bid_qty > MAX_Q) ? MAX_Q : bid_qty;
                    end
                end
                if (take_order) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.order_ready) begin
                    state_nxt = (COOLDOWN_CYC == 0) ? IDLE : COOL;
                end
            end
            COOL: begin
                if (cool_cnt == COOL_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Order fields are captured once in EVAL and held through ISSUE so book
    // traffic cannot disturb an order that is already on offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.order_side <= 1'b0;
            bus.order_px   <= '0;
            bus.order_qty  <= '0;
            cool_cnt       <= '0;
            drop_cnt       <= '0;
        end else begin
            if (take_order) begin
                bus.order_side <= eval_side;
                bus.order_px   <= eval_px;
                bus.order_qty  <= eval_qty;
            end
            if (state == COOL) begin
                cool_cnt <= cool_cnt + 1'b1;
            end else begin
                cool_cnt <= '0;
            end
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tob_momentum_engine.sv
// ----------------------------------------------------------------------------
// tb_tob_momentum_engine
// Directed scenarios followed by randomized frame traffic. A reference model
// tracks the book as plain integers and the engine's availability as edge
// timestamps (when an order becomes visible, until which edge triggers are
// dropped), and every output is compared after each clock edge.
// ----------------------------------------------------------------------------
module tb_tob_momentum_engine;

    localparam int PAYLOAD_LEN  = 4;
    localparam int PX_W         = 16;
    localparam int QTY_W        = 16;
    localparam int MAX_QTY      = 100;
    localparam int COOLDOWN_CYC = 8;

    logic clk = 1'b0;
    logic rst;

    logic [PX_W-1:0]  bid_px, ask_px, spread;
    logic [QTY_W-1:0] bid_qty, ask_qty;
    logic             bid_vld, ask_vld, crossed;
    logic [7:0]       drop_cnt;

    tob_momentum_engine_if #(.PAYLOAD_LEN(PAYLOAD_LEN), .PX_W(PX_W), .QTY_W(QTY_W)) bus ();

    tob_momentum_engine #(
        .PAYLOAD_LEN (PAYLOAD_LEN),
        .PX_W        (PX_W),
        .QTY_W       (QTY_W),
        .MAX_QTY     (MAX_QTY),
        .COOLDOWN_CYC(COOLDOWN_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .bid_px  (bid_px),
        .bid_qty (bid_qty),
        .bid_vld (bid_vld),
        .ask_px  (ask_px),
        .ask_qty (ask_qty),
        .ask_vld (ask_vld),
        .spread  (spread),
        .crossed (crossed),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    // Inputs presented at the upcoming edge.
    logic       s_v, s_rdy, s_rst;
    logic [1:0] s_t;
    int         s_px, s_qty;

    // Reference model state.
    int m_bid_px, m_bid_qty, m_ask_px, m_ask_qty;
    bit m_bid_v, m_ask_v;
    int m_drop;
    bit m_pending;
    int m_vis;
    int m_busy_end;
    int m_side, m_opx, m_oqty;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic modelReset();
        m_bid_px = 0; m_bid_qty = 0; m_bid_v = 0;
        m_ask_px = 0; m_ask_qty = 0; m_ask_v = 0;
        m_drop = 0; m_pending = 0; m_vis = 0; m_busy_end = -1;
        m_side = 0; m_opx = 0; m_oqty = 0;
    endtask

    // Applies the rules for one clock edge, using the book as it was before
    // this edge for any trade decision.
    task automatic modelEdge(input int e);
        bit busy;
        bit m_crossed;
        if (s_rst) begin
            modelReset();
            return;
        end
        busy = m_pending || (e <= m_busy_end);
        if (m_pending && (e > m_vis) && s_rdy) begin
            m_pending  = 0;
            m_busy_end = e + COOLDOWN_CYC;
        end
        if (s_v && s_t == 2'd2) begin
            if (busy) begin
                m_drop = min_int(m_drop + 1, 255);
            end else begin
                m_crossed = m_bid_v && m_ask_v && (m_ask_px <= m_bid_px);
                if (!m_crossed && m_ask_v && s_px >= m_ask_px) begin
                    m_pending = 1; m_vis = e + 1;
                    m_side = 0; m_opx = m_ask_px; m_oqty = min_int(m_ask_qty, MAX_QTY);
                end else if (!m_crossed && m_bid_v && s_px <= m_bid_px) begin
                    m_pending = 1; m_vis = e + 1;
                    m_side = 1; m_opx = m_bid_px; m_oqty = min_int(m_bid_qty, MAX_QTY);
                end else begin
                    m_busy_end = e + 1;
                end
            end
        end
        if (s_v && s_t == 2'd0) begin
            if (s_qty != 0) begin m_bid_px = s_px; m_bid_qty = s_qty; m_bid_v = 1; end
            else m_bid_v = 0;
        end
        if (s_v && s_t == 2'd1) begin
            if (s_qty != 0) begin m_ask_px = s_px; m_ask_qty = s_qty; m_ask_v = 1; end
            else m_ask_v = 0;
        end
        if (s_v && s_t == 2'd3) begin
            m_bid_v = 0; m_ask_v = 0;
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s at edge %0d: observed %0d, expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit exp_valid;
        int exp_spread;
        bit exp_crossed;
        exp_crossed = m_bid_v && m_ask_v && (m_ask_px <= m_bid_px);
        exp_spread  = (m_bid_v && m_ask_v && !exp_crossed) ? (m_ask_px - m_bid_px) : 0;
        exp_valid   = m_pending && (edge_n >= m_vis);
        checkValue("bid_vld", 32'(bid_vld), 32'(m_bid_v));
        checkValue("bid_px",  32'(bid_px),  32'(m_bid_px));
        checkValue("bid_qty", 32'(bid_qty), 32'(m_bid_qty));
        checkValue("ask_vld", 32'(ask_vld), 32'(m_ask_v));
        checkValue("ask_px",  32'(ask_px),  32'(m_ask_px));
        checkValue("ask_qty", 32'(ask_qty), 32'(m_ask_qty));
        checkValue("spread",  32'(spread),  32'(exp_spread));
        checkValue("crossed", 32'(crossed), 32'(exp_crossed));
        checkValue("order_valid", 32'(bus.order_valid), 32'(exp_valid));
        checkValue("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (exp_valid) begin
            checkValue("order_side", 32'(bus.order_side), 32'(m_side));
            checkValue("order_px",   32'(bus.order_px),   32'(m_opx));
            checkValue("order_qty",  32'(bus.order_qty),  32'(m_oqty));
        end
    endtask

    // Drives one frame (or none) for the next edge, advances the clock,
    // updates the model and compares all outputs shortly after the edge.
    task automatic applyStimulus(input logic v, input logic [1:0] t, input int px,
                                 input int qty, input logic rdy, input logic r);
        s_v = v; s_t = t; s_px = px; s_qty = qty; s_rdy = rdy; s_rst = r;
        bus.msg_valid   = v;
        bus.msg_type    = t;
        bus.msg_payload = {PX_W'(px), QTY_W'(qty)};
        bus.order_ready = rdy;
        rst             = r;
        @(posedge clk);
        edge_n++;
        modelEdge(edge_n);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 0, 0, rdy, 1'b0);
    endtask

    initial begin
        logic       rv, rr, rrst;
        logic [1:0] rt;
        int         rpx, rqty;

        modelReset();
        bus.msg_valid = 1'b0; bus.msg_type = 2'd0; bus.msg_payload = '0;
        bus.order_ready = 1'b0; rst = 1'b1;

        // T1: reset with a BID on the bus that must be ignored
        applyStimulus(1'b1, 2'd0, 100, 50, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd0, 100, 50, 1'b0, 1'b1);
        checkValue("t1_bid_vld", 32'(bid_vld), 32'd0);
        checkValue("t1_order_valid", 32'(bus.order_valid), 32'd0);
        checkValue("t1_drop_cnt", 32'(drop_cnt), 32'd0);

        // T2: build the book, then clear it
        applyStimulus(1'b1, 2'd0, 100, 50, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 104, 500, 1'b0, 1'b0);
        checkValue("t2_spread", 32'(spread), 32'd4);
        checkValue("t2_crossed", 32'(crossed), 32'd0);
        applyStimulus(1'b1, 2'd3, 0, 0, 1'b0, 1'b0);
        checkValue("t2_clear_vld", 32'({bid_vld, ask_vld}), 32'd0);
        checkValue("t2_clear_spread", 32'(spread), 32'd0);

        // T3: trade through the ask, ready already high
        applyStimulus(1'b1, 2'd0, 100, 50, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd1, 104, 500, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd2, 105, 0, 1'b1, 1'b0);
        checkValue("t3_not_yet_valid", 32'(bus.order_valid), 32'd0);
        applyStimulus(1'b0, 2'd0, 0, 0, 1'b1, 1'b0);
        checkValue("t3_valid", 32'(bus.order_valid), 32'd1);
        checkValue("t3_side", 32'(bus.order_side), 32'd0);
        checkValue("t3_px", 32'(bus.order_px), 32'd104);
        checkValue("t3_qty", 32'(bus.order_qty), 32'd100);
        applyStimulus(1'b0, 2'd0, 0, 0, 1'b1, 1'b0);
        checkValue("t3_accepted", 32'(bus.order_valid), 32'd0);
        idle(10, 1'b0);

        // T4: trade through the bid, ready withheld; extra trade dropped
        applyStimulus(1'b1, 2'd2, 99, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 99, 0, 1'b0, 1'b0);
        checkValue("t4_drop", 32'(drop_cnt), 32'd1);
        applyStimulus(1'b1, 2'd0, 100, 60, 1'b0, 1'b0);
        checkValue("t4_held_valid", 32'(bus.order_valid), 32'd1);
        checkValue("t4_side", 32'(bus.order_side), 32'd1);
        checkValue("t4_px", 32'(bus.order_px), 32'd100);
        checkValue("t4_qty_stable", 32'(bus.order_qty), 32'd50);
        applyStimulus(1'b0, 2'd0, 0, 0, 1'b1, 1'b0);
        checkValue("t4_accepted", 32'(bus.order_valid), 32'd0);

        // T5: trade during cooldown, crossed book, empty bid
        applyStimulus(1'b1, 2'd2, 130, 0, 1'b1, 1'b0);
        checkValue("t5_cool_drop", 32'(drop_cnt), 32'd2);
        idle(10, 1'b1);
        applyStimulus(1'b1, 2'd1, 99, 10, 1'b1, 1'b0);
        checkValue("t5_crossed", 32'(crossed), 32'd1);
        checkValue("t5_spread", 32'(spread), 32'd0);
        applyStimulus(1'b1, 2'd2, 120, 0, 1'b1, 1'b0);
        idle(3, 1'b1);
        checkValue("t5_no_order", 32'(bus.order_valid), 32'd0);
        applyStimulus(1'b1, 2'd0, 100, 0, 1'b1, 1'b0);
        checkValue("t5_bid_empty", 32'(bid_vld), 32'd0);

        // T6: reset while an order is on offer
        applyStimulus(1'b1, 2'd0, 100, 50, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 104, 500, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd2, 105, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 0, 0, 1'b0, 1'b0);
        checkValue("t6_valid_before", 32'(bus.order_valid), 32'd1);
        applyStimulus(1'b0, 2'd0, 0, 0, 1'b0, 1'b1);
        checkValue("t6_valid_after", 32'(bus.order_valid), 32'd0);
        idle(3, 1'b1);

        // Randomized traffic around a narrow price band
        for (int i = 0; i < 3000; i++) begin
            rv   = ($urandom_range(0, 2) != 0);
            rt   = 2'($urandom_range(0, 3));
            rpx  = 90 + int'($urandom_range(0, 20));
            rqty = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 300));
            rr   = ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 299) == 0);
            applyStimulus(rv, rt, rpx, rqty, rr, rrst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
